// File: rtl/ram_sdp_be_clr.sv
// Simple dual-port RAM on one clock with per-lane write enables, same-address bypass,
// an optional output register and a sequential clear engine.
module ram_sdp_be_clr #(
  parameter int unsigned   DW        = 16,
  parameter int unsigned   AW        = 14,
  parameter int unsigned   LANE_W    = 8,
  parameter int unsigned   BYPASS    = 1,
  parameter int unsigned   OUT_REG   = 0,
  parameter logic [DW-1:0] CLR_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW/LANE_W-1:0] wr_be,
  input  logic [DW-1:0]        wr_data,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_valid,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic                 clr_done
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned NL    = DW / LANE_W;

  typedef enum logic {IDLE, CLEAR} clrState_t;

  clrState_t       state, nextState;
  logic [AW-1:0]   clrCnt;
  logic            clrLast, clrWrite;
  logic            wrAcc, rdAcc;
  logic [DW-1:0]   rdWord;
  logic [DW-1:0]   s1Data;
  logic            s1Valid;
  logic [DW-1:0]   mem [DEPTH];

  assign clrLast = &clrCnt;
  assign wrAcc   = wr_en & ~clr_busy;
  assign rdAcc   = rd_en & ~clr_busy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (clr_start) nextState = CLEAR;
      CLEAR:   if (clrLast)   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The clear write is suppressed on a reset edge so that only entries below clrCnt end up cleared.
  always_comb begin
    clr_busy = (state == CLEAR);
    clrWrite = clr_busy & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clrCnt   <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= clrWrite & clrLast;
      if (clrWrite) clrCnt <= clrLast ? '0 : clrCnt + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clrWrite) begin
      mem[clrCnt] <= CLR_VALUE;
    end else if (wrAcc) begin
      for (int unsigned i = 0; i < NL; i++)
        if (wr_be[i]) mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
    end
  end

  // Array reads see pre-write contents; bypass merges the enabled lanes of a colliding write.
  always_comb begin
    rdWord = mem[rd_addr];
    if (BYPASS != 0 && wrAcc && wr_addr == rd_addr) begin
      for (int unsigned i = 0; i < NL; i++)
        if (wr_be[i]) rdWord[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid  <= 1'b0;
      s1Data   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      s1Valid <= rdAcc;
      if (rdAcc) s1Data <= rdWord;
      if (OUT_REG != 0) begin
        rd_valid <= s1Valid;
        if (s1Valid) rd_data <= s1Data;
      end else begin
        rd_valid <= rdAcc;
        if (rdAcc) rd_data <= rdWord;
      end
    end
  end

endmodule

// File: tb/tb_ram_sdp_be_clr.sv
// Drives a bypass/latency-1 instance and a no-bypass/latency-2 instance with identical stimulus
// and checks reads through per-instance expectation queues.
module tb_ram_sdp_be_clr;

  typedef struct {
    logic [15:0] d;
    int          c;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst, wrEn, rdEn, clrStart;
  logic [3:0]  wrAddr, rdAddr;
  logic [1:0]  wrBe;
  logic [15:0] wrData;
  logic [15:0] dA, dB;
  logic        vA, vB, busyA, busyB, doneA, doneB;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int busyCycA = 0, busyCycB = 0, doneCntA = 0, doneCntB = 0;
  int bBusyA, bBusyB, bDoneA, bDoneB;
  rec_t expA[$], expB[$], obsA[$], obsB[$];

  ram_sdp_be_clr #(.DW(16), .AW(4), .LANE_W(8), .BYPASS(1), .OUT_REG(0), .CLR_VALUE(16'hDEAD)) dutA (
    .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_be(wrBe), .wr_data(wrData),
    .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(dA), .rd_valid(vA),
    .clr_start(clrStart), .clr_busy(busyA), .clr_done(doneA));

  ram_sdp_be_clr #(.DW(16), .AW(4), .LANE_W(8), .BYPASS(0), .OUT_REG(1), .CLR_VALUE(16'hDEAD)) dutB (
    .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_be(wrBe), .wr_data(wrData),
    .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(dB), .rd_valid(vB),
    .clr_start(clrStart), .clr_busy(busyB), .clr_done(doneB));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vA) obsA.push_back('{d: dA, c: cyc});
    if (vB) obsB.push_back('{d: dB, c: cyc});
    if (busyA) busyCycA++;
    if (busyB) busyCycB++;
    if (doneA) doneCntA++;
    if (doneB) doneCntB++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wrEn = 1'b0; rdEn = 1'b0; clrStart = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] be, input logic [15:0] d);
    wrEn = 1'b1; wrAddr = a; wrBe = be; wrData = d;
    tick();
    idle();
  endtask

  // Arms a read for the next edge; A answers after one edge, B after two.
  task automatic armRead(input logic [3:0] a, input logic [15:0] eA, input logic [15:0] eB);
    rdEn = 1'b1; rdAddr = a;
    expA.push_back('{d: eA, c: cyc + 1});
    expB.push_back('{d: eB, c: cyc + 2});
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] eA, input logic [15:0] eB);
    armRead(a, eA, eB);
    tick();
    idle();
  endtask

  task automatic checkReads(input string ph);
    rec_t e, o;
    repeat (3) tick();
    while (expA.size() > 0) begin
      e = expA.pop_front();
      if (obsA.size() > 0) o = obsA.pop_front();
      else o = '{d: 'x, c: -1};
      check({ph, " A data"}, 32'(o.d), 32'(e.d));
      check({ph, " A cycle"}, o.c, e.c);
    end
    check({ph, " A extra reads"}, obsA.size(), 0);
    while (expB.size() > 0) begin
      e = expB.pop_front();
      if (obsB.size() > 0) o = obsB.pop_front();
      else o = '{d: 'x, c: -1};
      check({ph, " B data"}, 32'(o.d), 32'(e.d));
      check({ph, " B cycle"}, o.c, e.c);
    end
    check({ph, " B extra reads"}, obsB.size(), 0);
    obsA.delete();
    obsB.delete();
  endtask

  initial begin
    rst = 1'b1; idle();
    wrAddr = '0; rdAddr = '0; wrBe = '0; wrData = '0;
    repeat (3) tick();
    check("reset rd_data A", 32'(dA), 0);
    check("reset rd_data B", 32'(dB), 0);
    check("reset rd_valid A", 32'(vA), 0);
    check("reset rd_valid B", 32'(vB), 0);
    check("reset clr_busy A", 32'(busyA), 0);
    check("reset clr_busy B", 32'(busyB), 0);
    check("reset clr_done A", 32'(doneA), 0);
    check("reset clr_done B", 32'(doneB), 0);
    rst = 1'b0;
    tick();

    wr(4'd3, 2'b11, 16'hA5C3);
    rd(4'd3, 16'hA5C3, 16'hA5C3);
    checkReads("full write");

    wr(4'd5, 2'b11, 16'h1234);
    wr(4'd5, 2'b01, 16'hFFEE);
    rd(4'd5, 16'h12EE, 16'h12EE);
    checkReads("partial write");

    wr(4'd7, 2'b11, 16'h0000);
    wrEn = 1'b1; wrAddr = 4'd7; wrBe = 2'b10; wrData = 16'hBEEF;
    armRead(4'd7, 16'hBE00, 16'h0000);
    tick();
    idle();
    rd(4'd7, 16'hBE00, 16'hBE00);
    checkReads("collision");

    wr(4'd1, 2'b11, 16'h0011);
    wr(4'd2, 2'b11, 16'h0022);
    wr(4'd3, 2'b11, 16'h0033);
    rd(4'd1, 16'h0011, 16'h0011);
    rd(4'd2, 16'h0022, 16'h0022);
    rd(4'd3, 16'h0033, 16'h0033);
    checkReads("back-to-back");

    for (int i = 0; i < 16; i++) wr(4'(i), 2'b11, 16'hC000 | 16'(i));

    bBusyA = busyCycA; bDoneA = doneCntA; bDoneB = doneCntB;
    clrStart = 1'b1;
    tick();
    idle();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("abort clr_busy A", 32'(busyA), 0);
    check("abort clr_busy B", 32'(busyB), 0);
    check("abort rd_data A", 32'(dA), 0);
    check("abort rd_data B", 32'(dB), 0);
    check("abort busy cycles", busyCycA - bBusyA, 5);
    rst = 1'b0;
    tick();
    check("abort clr_done A", doneCntA - bDoneA, 0);
    check("abort clr_done B", doneCntB - bDoneB, 0);
    for (int i = 0; i < 16; i++)
      if (i < 4) rd(4'(i), 16'hDEAD, 16'hDEAD);
      else       rd(4'(i), 16'hC000 | 16'(i), 16'hC000 | 16'(i));
    checkReads("partial clear");

    bBusyA = busyCycA; bBusyB = busyCycB; bDoneA = doneCntA; bDoneB = doneCntB;
    clrStart = 1'b1;
    armRead(4'd9, 16'hC009, 16'hC009);
    tick();
    idle();
    for (int n = 0; n < 40; n++) begin
      if (doneCntA != bDoneA) break;
      if (n == 2) begin
        wrEn = 1'b1; wrAddr = 4'd9; wrBe = 2'b11; wrData = 16'h7777;
        rdEn = 1'b1; rdAddr = 4'd9; clrStart = 1'b1;
      end
      tick();
      idle();
    end
    repeat (3) tick();
    check("clear busy cycles A", busyCycA - bBusyA, 16);
    check("clear busy cycles B", busyCycB - bBusyB, 16);
    check("clear done pulses A", doneCntA - bDoneA, 1);
    check("clear done pulses B", doneCntB - bDoneB, 1);
    checkReads("read at clear start");
    for (int i = 0; i < 16; i++) rd(4'(i), 16'hDEAD, 16'hDEAD);
    checkReads("after clear");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
